// File: rtl/cmach_brew_seq_if.sv
// rtl/cmach_brew_seq_if.sv - control and actuator bundle between brew sequencer and its neighbours
interface cmach_brew_seq_if;
    logic        tick;
    logic        start;
    logic        abort;
    logic [18:0] recipe_in;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        filter_load;
    logic        grinder_on;
    logic        water_on;
    logic        pump_on;
    logic        press_hi;
    logic        cocoa_on;
    logic        creamer_on;
    logic [2:0]  phase;

    modport master (
        output tick, start, abort, recipe_in,
        input  busy, done, aborted, filter_load, grinder_on, water_on,
               pump_on, press_hi, cocoa_on, creamer_on, phase
    );

    modport slave (
        input  tick, start, abort, recipe_in,
        output busy, done, aborted, filter_load, grinder_on, water_on,
               pump_on, press_hi, cocoa_on, creamer_on, phase
    );
endinterface

// File: rtl/cmach_brew_seq.sv
// rtl/cmach_brew_seq.sv - coffee brew sequencer stepping actuators through timed recipe phases
module cmach_brew_seq #(
    parameter int FILTER_TICKS = 2,
    parameter int CREAM_TICKS  = 3
) (
    input  logic             clk,
    input  logic             rst,
    cmach_brew_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILTER = 3'd1,
        S_GRIND  = 3'd2,
        S_WATER  = 3'd3,
        S_POUR   = 3'd4,
        S_COCOA  = 3'd5,
        S_CREAM  = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    localparam logic [3:0] FILTER_DUR = 4'(FILTER_TICKS);
    localparam logic [3:0] CREAM_DUR  = 4'(CREAM_TICKS);

    state_t      state_q, state_d;
    logic [3:0]  timer_q, timer_d;
    logic [18:0] recipe_q, recipe_d;
    logic        aborted_q, aborted_d;

    // Zero duration means the phase is skipped entirely.
    function automatic logic [3:0] phase_dur(input state_t p, input logic [18:0] r);
        case (p)
            S_FILTER: phase_dur = r[18] ? FILTER_DUR : 4'd0;
            S_GRIND:  phase_dur = r[8:5];
            S_WATER:  phase_dur = r[12:9];
            S_POUR:   phase_dur = r[16:13];
            S_COCOA:  phase_dur = r[4:1];
            S_CREAM:  phase_dur = r[0] ? CREAM_DUR : 4'd0;
            default:  phase_dur = 4'd0;
        endcase
    endfunction

    function automatic state_t next_phase(input state_t p, input logic [18:0] r);
        state_t n;
        n = S_DONE;
        for (int i = 6; i >= 1; i--) begin
            if (i > int'(p) && phase_dur(state_t'(3'(i)), r) != 4'd0) begin
                n = state_t'(3'(i));
            end
        end
        return n;
    endfunction

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        recipe_d  = recipe_q;
        aborted_d = 1'b0;
        if (state_q != S_IDLE && bus.abort) begin
            state_d   = S_IDLE;
            timer_d   = 4'd0;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        recipe_d = bus.recipe_in;
                        state_d  = next_phase(S_IDLE, bus.recipe_in);
                        timer_d  = phase_dur(state_d, bus.recipe_in);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    timer_d = 4'd0;
                end
                default: begin
                    if (bus.tick) begin
                        if (timer_q == 4'd1) begin
                            state_d = next_phase(state_q, recipe_q);
                            timer_d = phase_dur(state_d, recipe_q);
                        end else begin
                            timer_d = timer_q - 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= 4'd0;
            recipe_q  <= 19'd0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            recipe_q  <= recipe_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        bus.busy        = (state_q != S_IDLE);
        bus.done        = (state_q == S_DONE);
        bus.aborted     = aborted_q;
        bus.filter_load = (state_q == S_FILTER);
        bus.grinder_on  = (state_q == S_GRIND);
        bus.water_on    = (state_q == S_WATER);
        bus.pump_on     = (state_q == S_POUR);
        bus.press_hi    = (state_q == S_POUR) && recipe_q[17];
        bus.cocoa_on    = (state_q == S_COCOA);
        bus.creamer_on  = (state_q == S_CREAM);
        bus.phase       = state_q;
    end

endmodule
